// File: rtl/gps_epoch_scheduler_if.sv
// Wishbone classic read bus between the epoch scheduler (master) and the
// correlator register windows (slave).
interface gps_epoch_scheduler_if;
   logic [31:0] m_adr_o;
   logic        m_cyc_o;
   logic        m_stb_o;
   logic        m_we_o;
   logic [31:0] m_dat_i;
   logic        m_ack_i;

   modport master (
      output m_adr_o, m_cyc_o, m_stb_o, m_we_o,
      input  m_dat_i, m_ack_i
   );

   modport slave (
      input  m_adr_o, m_cyc_o, m_stb_o, m_we_o,
      output m_dat_i, m_ack_i
   );
endinterface

// File: rtl/gps_epoch_scheduler.sv
// Round-robin Wishbone readout of 8 correlator channels into a tagged FWFT FIFO.
// Optional ack timeout enabled by defining GPS_SCHED_TIMEOUT_EN.
module gps_epoch_scheduler #(
   parameter int             NREG       = 4,
   parameter logic [7:0]     REG_OFS    = 8'h10,
   parameter int             FIFO_DEPTH = 16,
   parameter int             TIMEOUT    = 15
) (
   input  logic                         mclk,
   input  logic                         mclr,
   input  logic [7:0]                   epoch_i,
   input  logic                         enable_i,
   input  logic                         clr_ovr_i,
   gps_epoch_scheduler_if.master        wb,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_data,
   output logic [7:0]                   out_tag,
   output logic [7:0]                   overrun_o,
   output logic                         busy_o
);

   localparam int CW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
`ifdef GPS_SCHED_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    epoch_q, pend_q, pend_d, ovr_q, ovr_d;
   logic [7:0]    rise, grant_oh;
   logic [2:0]    last_ch_q, last_ch_d, ch_q, ch_d, idx_q, idx_d;
   logic [2:0]    cand, win_ch;
   logic          win_found, can_start, ack_ev, tmo_hit;
   logic          cyc_q, cyc_d;
   logic [31:0]   adr_q, adr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [CW:0]   cnt_q, cnt_d, free_slots;
   logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic          push, pop;
   logic [31:0]   wr_data;
   logic [7:0]    wr_tag;
   logic [31:0]   dmem_q [FIFO_DEPTH];
   logic [7:0]    tmem_q [FIFO_DEPTH];

   function automatic logic [31:0] win_addr(input logic [2:0] c, input logic [2:0] i);
      return {16'h0000, 8'h0A + {5'd0, c}, REG_OFS + {3'd0, i, 2'b00}};
   endfunction

   // Without the timeout option the counter is dead logic and tmo_hit is tied low.
   assign tmo_hit = TMO_EN && (state_q == READ) && !wb.m_ack_i
                    && (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      rise       = epoch_i & ~epoch_q;
      win_found  = 1'b0;
      win_ch     = last_ch_q;
      cand       = last_ch_q;
      for (int i = 1; i <= 8; i++) begin
         cand = last_ch_q + 3'(i);
         if (!win_found && pend_q[cand]) begin
            win_found = 1'b1;
            win_ch    = cand;
         end
      end

      free_slots = (CW+1)'(FIFO_DEPTH) - cnt_q;
      can_start  = enable_i && win_found && (free_slots >= (CW+1)'(NREG));
      ack_ev     = (state_q == READ) && (wb.m_ack_i || tmo_hit);
      push       = ack_ev;
      pop        = (cnt_q != '0) && out_ready;
      wr_data    = tmo_hit ? 32'hDEADBEEF : wb.m_dat_i;
      wr_tag     = {tmo_hit, idx_q == 3'(NREG - 1), ch_q, idx_q};

      state_d    = state_q;
      ch_d       = ch_q;
      last_ch_d  = last_ch_q;
      idx_d      = idx_q;
      cyc_d      = cyc_q;
      adr_d      = adr_q;
      grant_oh   = 8'h00;
      tmo_d      = ((state_q == READ) && !ack_ev) ? tmo_q + 1'b1 : '0;

      case (state_q)
         IDLE: if (can_start) begin
            state_d   = READ;
            grant_oh  = 8'h01 << win_ch;
            ch_d      = win_ch;
            last_ch_d = win_ch;
            idx_d     = 3'd0;
            cyc_d     = 1'b1;
            adr_d     = win_addr(win_ch, 3'd0);
         end
         READ: if (ack_ev) begin
            if (idx_q == 3'(NREG - 1)) begin
               state_d = DONE;
               cyc_d   = 1'b0;
            end else begin
               idx_d = idx_q + 3'd1;
               adr_d = win_addr(ch_q, idx_q + 3'd1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A rise landing on the grant cycle re-arms the channel without an overrun.
      pend_d = (pend_q & ~grant_oh) | rise;
      ovr_d  = (clr_ovr_i ? 8'h00 : ovr_q) | (rise & pend_q & ~grant_oh);

      wptr_d = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!mclr) begin
         state_q   <= IDLE;
         epoch_q   <= 8'h00;
         pend_q    <= 8'h00;
         ovr_q     <= 8'h00;
         last_ch_q <= 3'd7;
         ch_q      <= 3'd0;
         idx_q     <= 3'd0;
         cyc_q     <= 1'b0;
         adr_q     <= 32'h0;
         tmo_q     <= '0;
         cnt_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
      end else begin
         state_q   <= state_d;
         epoch_q   <= epoch_i;
         pend_q    <= pend_d;
         ovr_q     <= ovr_d;
         last_ch_q <= last_ch_d;
         ch_q      <= ch_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         adr_q     <= adr_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
      end
   end

   always_ff @(posedge mclk) begin
      if (push) begin
         dmem_q[wptr_q] <= wr_data;
         tmem_q[wptr_q] <= wr_tag;
      end
   end

   assign wb.m_adr_o = adr_q;
   assign wb.m_cyc_o = cyc_q;
   assign wb.m_stb_o = cyc_q;
   assign wb.m_we_o  = 1'b0;
   assign out_valid  = (cnt_q != '0);
   assign out_data   = dmem_q[rptr_q];
   assign out_tag    = tmem_q[rptr_q];
   assign overrun_o  = ovr_q;
   assign busy_o     = (state_q != IDLE);

endmodule
